// File: rtl/d_mem_bridge8.sv
// Bridges the core's 16-bit data-memory port onto a single 8-bit synchronous SRAM.
// Word accesses are split into even/odd byte accesses with optional wait states; a write to HALT_ADDR raises a sticky halt flag.
module d_mem_bridge8 #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [15:0] HALT_ADDR   = 16'hFFFE
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              d_mem_assert,
  input  logic              d_mem_cmd,
  input  logic              d_mem_be0,
  input  logic              d_mem_be1,
  input  logic [15:0]       d_mem_addr,
  input  logic [15:0]       d_mem_wdata,
  output logic [15:0]       d_mem_rdata,
  output logic              d_mem_rdy,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata,
  output logic              halt
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              cmd_q, cmd_d;
  logic              word_q, word_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              rdy_q, rdy_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;
  logic [7:0]        swdata_q, swdata_d;
  logic              halt_q, halt_d;
  logic [15:0]       byte_addr;

  // Next-state and next-output logic; outputs are derived from the next state so they are registered.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    word_d    = word_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rdy_d     = 1'b0;
    en_d      = 1'b0;
    we_d      = 1'b0;
    saddr_d   = saddr_q;
    swdata_d  = swdata_q;
    halt_d    = halt_q;
    byte_addr = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (d_mem_assert) begin
          state_d = S_ISSUE;
          cmd_d   = d_mem_cmd;
          word_d  = d_mem_be0 & d_mem_be1;
          addr_d  = d_mem_addr;
          wdata_d = d_mem_wdata;
          idx_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        if (WS != 4'd0) begin
          state_d = S_WAIT;
          cnt_d   = WS - 4'd1;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CAPTURE: begin
        if (!cmd_q) begin
          if (!word_q)     rdata_d       = {8'h00, sram_rdata};
          else if (!idx_q) rdata_d[15:8] = sram_rdata;
          else             rdata_d[7:0]  = sram_rdata;
        end
        if (word_q && !idx_q) begin
          state_d = S_ISSUE;
          idx_d   = 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Even byte first for words; addr[0] is ignored on word accesses.
    byte_addr = word_d ? {addr_d[15:1], idx_d} : addr_d;
    if (state_d == S_ISSUE) begin
      en_d     = 1'b1;
      we_d     = cmd_d;
      saddr_d  = ADDR_W'(byte_addr);
      swdata_d = (word_d && !idx_d) ? wdata_d[15:8] : wdata_d[7:0];
    end

    if (state_d == S_RESP) begin
      rdy_d = 1'b1;
      if (cmd_q && ({addr_q[15:1], 1'b0} == HALT_ADDR)) halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= 1'b0;
      word_q   <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      idx_q    <= 1'b0;
      cnt_q    <= 4'd0;
      rdata_q  <= 16'h0000;
      rdy_q    <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      saddr_q  <= '0;
      swdata_q <= 8'h00;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rdy_q    <= rdy_d;
      en_q     <= en_d;
      we_q     <= we_d;
      saddr_q  <= saddr_d;
      swdata_q <= swdata_d;
      halt_q   <= halt_d;
    end
  end

  assign d_mem_rdata = rdata_q;
  assign d_mem_rdy   = rdy_q;
  assign sram_en     = en_q;
  assign sram_we     = we_q;
  assign sram_addr   = saddr_q;
  assign sram_wdata  = swdata_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_d_mem_bridge8.sv
// Directed bench for d_mem_bridge8: one instance with no wait states, one with two,
// each backed by its own behavioural 8-bit SRAM preset to mem[i] = i[15:8].
module tb_d_mem_bridge8;

  logic        clk;
  logic        a_rst;
  logic        assert0, assert2;
  logic        cmd, be0, be1;
  logic [15:0] addr, wdata;

  logic [15:0] rdata0, rdata2;
  logic        rdy0, rdy2, en0, en2, we0, we2, halt0, halt2;
  logic [15:0] saddr0, saddr2;
  logic [7:0]  swd0, swd2, srd0, srd2;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  d_mem_bridge8 #(.ADDR_W(16), .WAIT_STATES(0), .HALT_ADDR(16'hFFFE)) u_dut0 (
    .clk(clk), .a_rst(a_rst), .d_mem_assert(assert0), .d_mem_cmd(cmd),
    .d_mem_be0(be0), .d_mem_be1(be1), .d_mem_addr(addr), .d_mem_wdata(wdata),
    .d_mem_rdata(rdata0), .d_mem_rdy(rdy0), .sram_en(en0), .sram_we(we0),
    .sram_addr(saddr0), .sram_wdata(swd0), .sram_rdata(srd0), .halt(halt0));

  d_mem_bridge8 #(.ADDR_W(16), .WAIT_STATES(2), .HALT_ADDR(16'hFFFE)) u_dut2 (
    .clk(clk), .a_rst(a_rst), .d_mem_assert(assert2), .d_mem_cmd(cmd),
    .d_mem_be0(be0), .d_mem_be1(be1), .d_mem_addr(addr), .d_mem_wdata(wdata),
    .d_mem_rdata(rdata2), .d_mem_rdy(rdy2), .sram_en(en2), .sram_we(we2),
    .sram_addr(saddr2), .sram_wdata(swd2), .sram_rdata(srd2), .halt(halt2));

  always #5 clk = ~clk;

  // Behavioural SRAMs: unwritten locations read back their preset value a[15:8].
  logic [7:0] mem0 [0:65535];
  logic [7:0] mem2 [0:65535];
  bit         wr0  [0:65535];
  bit         wr2  [0:65535];

  always @(posedge clk) begin
    if (en0) begin
      if (we0) begin mem0[saddr0] <= swd0; wr0[saddr0] <= 1'b1; end
      else srd0 <= wr0[saddr0] ? mem0[saddr0] : saddr0[15:8];
    end
    if (en2) begin
      if (we2) begin mem2[saddr2] <= swd2; wr2[saddr2] <= 1'b1; end
      else srd2 <= wr2[saddr2] ? mem2[saddr2] : saddr2[15:8];
    end
  end

  function automatic logic [7:0] rd0(input logic [15:0] a);
    return wr0[a] ? mem0[a] : a[15:8];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, hold it until rdy, and report latency and SRAM activity.
  task automatic run(input bit use2, input bit c, input bit b0, input bit b1,
                     input logic [15:0] a, input logic [15:0] wd,
                     output int lat, output int ens, output int wes,
                     output logic [15:0] a_first, output logic [15:0] a_second,
                     output logic halt_at_rdy);
    bit done;
    @(negedge clk);
    @(negedge clk);
    cmd = c; be0 = b0; be1 = b1; addr = a; wdata = wd;
    if (use2) assert2 = 1'b1; else assert0 = 1'b1;
    @(posedge clk); #1;
    lat = 0; ens = 0; wes = 0; done = 1'b0;
    a_first = 16'h0; a_second = 16'h0; halt_at_rdy = 1'b0;
    while (!done && lat < 40) begin
      if (use2 ? en2 : en0) begin
        if (ens == 0) a_first = use2 ? saddr2 : saddr0;
        else          a_second = use2 ? saddr2 : saddr0;
        ens++;
        if (use2 ? we2 : we0) wes++;
      end
      if (use2 ? rdy2 : rdy0) begin
        done = 1'b1;
        halt_at_rdy = use2 ? halt2 : halt0;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    assert0 = 1'b0;
    assert2 = 1'b0;
    check("rdy_timeout", 32'(done), 32'd1);
  endtask

  int          lat, ens, wes, rcount, r1, r2;
  logic [15:0] af, as2;
  logic        hr;

  initial begin
    clk = 1'b0; a_rst = 1'b0; assert0 = 1'b0; assert2 = 1'b0;
    cmd = 1'b0; be0 = 1'b0; be1 = 1'b0; addr = 16'h0; wdata = 16'h0;
    #2;
    check("rst_rdata", 32'(rdata0), 32'h0);
    check("rst_ctrl", 32'({rdy0, en0, we0, halt0}), 32'h0);
    check("rst_sram", 32'({saddr0, swd0}), 32'h0);
    repeat (3) @(negedge clk);
    a_rst = 1'b1;

    run(1'b0, 1'b0, 1'b0, 1'b0, 16'hC05A, 16'h0, lat, ens, wes, af, as2, hr);
    check("byte_rd_data", 32'(rdata0), 32'h00C0);
    check("byte_rd_lat", 32'(lat), 32'd2);
    check("byte_rd_en", 32'(ens), 32'd1);
    check("byte_rd_we", 32'(wes), 32'd0);
    check("byte_rd_addr", 32'(af), 32'hC05A);

    run(1'b0, 1'b0, 1'b1, 1'b1, 16'h1235, 16'h0, lat, ens, wes, af, as2, hr);
    check("word_rd_data", 32'(rdata0), 32'h1212);
    check("word_rd_lat", 32'(lat), 32'd4);
    check("word_rd_en", 32'(ens), 32'd2);

    run(1'b1, 1'b0, 1'b1, 1'b1, 16'h1235, 16'h0, lat, ens, wes, af, as2, hr);
    check("ws2_rd_data", 32'(rdata2), 32'h1212);
    check("ws2_rd_lat", 32'(lat), 32'd8);
    check("ws2_addr0", 32'(af), 32'h1234);
    check("ws2_addr1", 32'(as2), 32'h1235);

    run(1'b0, 1'b1, 1'b1, 1'b1, 16'hB011, 16'hBEEF, lat, ens, wes, af, as2, hr);
    check("word_wr_lat", 32'(lat), 32'd4);
    check("word_wr_we", 32'(wes), 32'd2);
    check("word_wr_even", 32'(rd0(16'hB010)), 32'hBE);
    check("word_wr_odd", 32'(rd0(16'hB011)), 32'hEF);
    check("word_wr_keep_rdata", 32'(rdata0), 32'h1212);

    run(1'b0, 1'b0, 1'b0, 1'b1, 16'hB011, 16'h0, lat, ens, wes, af, as2, hr);
    check("rdback_b011", 32'(rdata0), 32'h00EF);

    run(1'b0, 1'b1, 1'b1, 1'b0, 16'hB020, 16'h1234, lat, ens, wes, af, as2, hr);
    check("byte_wr_lat", 32'(lat), 32'd2);
    check("byte_wr_b020", 32'(rd0(16'hB020)), 32'h34);
    check("byte_wr_b021", 32'(rd0(16'hB021)), 32'hB0);
    check("byte_wr_keep_rdata", 32'(rdata0), 32'h00EF);

    run(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFE, 16'h0, lat, ens, wes, af, as2, hr);
    check("halt_rd_data", 32'(rdata0), 32'hFFFF);
    check("halt_rd_noset", 32'(halt0), 32'd0);

    run(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h00AA, lat, ens, wes, af, as2, hr);
    check("halt_in_resp", 32'(hr), 32'd1);
    check("halt_wr_done", 32'(rd0(16'hFFFF)), 32'hAA);

    run(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0, lat, ens, wes, af, as2, hr);
    check("halt_sticky_data", 32'(rdata0), 32'h0001);
    check("halt_sticky", 32'(halt0), 32'd1);

    // Reset asserted while the wait-state instance sits in WAIT of a word read.
    @(negedge clk);
    @(negedge clk);
    cmd = 1'b0; be0 = 1'b1; be1 = 1'b1; addr = 16'h1235; assert2 = 1'b1;
    @(posedge clk); #1;
    check("rstw_issue_en", 32'(en2), 32'd1);
    @(posedge clk); #1;
    check("rstw_wait_en", 32'(en2), 32'd0);
    a_rst = 1'b0;
    #1;
    check("rstw_ctrl", 32'({rdy2, en2, we2, halt2}), 32'h0);
    check("rstw_data", 32'({rdata2, saddr2, swd2}), 32'h0);
    check("rstw_halt0", 32'(halt0), 32'd0);
    assert2 = 1'b0;
    @(negedge clk);
    a_rst = 1'b1;
    rcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (rdy2) rcount++;
    end
    check("rstw_no_rdy", 32'(rcount), 32'd0);

    // Back-to-back byte reads: request held through the first completion.
    @(negedge clk);
    cmd = 1'b0; be0 = 1'b0; be1 = 1'b0; addr = 16'hC05A; assert0 = 1'b1;
    @(posedge clk); #1;
    r1 = -1; r2 = -1;
    for (int k = 0; k < 20; k++) begin
      if (rdy0) begin
        if (r1 < 0) begin
          r1 = k;
          check("b2b_first_data", 32'(rdata0), 32'h00C0);
          addr = 16'h3400;
        end else if (r2 < 0) begin
          r2 = k;
          assert0 = 1'b0;
        end
      end
      if (r2 >= 0) break;
      @(posedge clk); #1;
    end
    assert0 = 1'b0;
    check("b2b_first_rdy", 32'(r1), 32'd2);
    check("b2b_second_rdy", 32'(r2), 32'd6);
    check("b2b_second_data", 32'(rdata0), 32'h0034);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
